// File: rtl/reg_access_seq.sv
// Operand-fetch / writeback sequencer in front of a registered-read register file.
// Absorbs the one-cycle read latency and forwards writes into pending operands.
module reg_access_seq #(
  parameter int NREG = 16,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_sr1,
  input  logic [AW-1:0] req_sr2,
  input  logic          req_use1,
  input  logic          req_use2,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          err,
  output logic [1:0]    rf_readreg,
  output logic [AW-1:0] rf_sr1,
  output logic [AW-1:0] rf_sr2,
  output logic [AW-1:0] rf_dr,
  output logic          rf_wreg,
  output logic          rf_muxa2,
  output logic [DW-1:0] rf_wrData,
  input  logic [DW-1:0] rf_rdData1,
  input  logic [DW-1:0] rf_rdData2,
  output logic [1:0]    fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid holds its payload until then, ready may depend on state and rst.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_d;

  logic [AW-1:0] sr1_q, sr2_q;
  logic          use1_q, use2_q;
  logic          fwd1_v, fwd2_v;
  logic [DW-1:0] fwd1_d, fwd2_d;

  logic          accept;
  logic          wb_fire;
  logic          wb_ok;
  logic          err_d;
  logic [DW-1:0] cap_a, cap_b;

  function automatic logic out_of_range(input logic [AW-1:0] a);
    return int'(a) >= NREG;
  endfunction

  // True when an in-range write this cycle targets address a.
  function automatic logic wb_hit(input logic ok, input logic [AW-1:0] wa,
                                  input logic [AW-1:0] a);
    return ok && (wa == a);
  endfunction

  assign fsm_state = state;
  assign rf_muxa2  = 1'b0;

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    wb_ready   = ~rst;
    wb_fire    = wb_valid & ~rst;
    wb_ok      = wb_fire & ~out_of_range(wb_addr);
    rf_readreg = 2'b00;
    rf_sr1     = '0;
    rf_sr2     = '0;
    rf_wreg    = wb_ok;
    rf_dr      = wb_fire ? wb_addr : '0;
    rf_wrData  = wb_fire ? wb_data : '0;
    err_d      = wb_fire & out_of_range(wb_addr);
    cap_a      = '0;
    cap_b      = '0;

    case (state)
      IDLE: begin
        req_ready = ~rst;
        accept    = req_valid & ~rst;
        if (accept) begin
          rf_readreg = {req_use1, req_use2};
          rf_sr1     = req_sr1;
          rf_sr2     = req_sr2;
          err_d      = err_d | (req_use1 & out_of_range(req_sr1))
                             | (req_use2 & out_of_range(req_sr2));
          state_d    = CAPT;
        end
      end
      CAPT: begin
        // Priority: write landing now, then write seen at accept, then RF data.
        if (use1_q && !out_of_range(sr1_q)) begin
          if (wb_hit(wb_ok, wb_addr, sr1_q)) cap_a = wb_data;
          else if (fwd1_v)                   cap_a = fwd1_d;
          else                               cap_a = rf_rdData1;
        end
        if (use2_q && !out_of_range(sr2_q)) begin
          if (wb_hit(wb_ok, wb_addr, sr2_q)) cap_b = wb_data;
          else if (fwd2_v)                   cap_b = fwd2_d;
          else                               cap_b = rf_rdData2;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      err      <= 1'b0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      use1_q   <= 1'b0;
      use2_q   <= 1'b0;
      fwd1_v   <= 1'b0;
      fwd2_v   <= 1'b0;
      fwd1_d   <= '0;
      fwd2_d   <= '0;
    end else begin
      state <= state_d;
      err   <= err_d;
      case (state)
        IDLE: begin
          if (accept) begin
            sr1_q  <= req_sr1;
            sr2_q  <= req_sr2;
            use1_q <= req_use1;
            use2_q <= req_use2;
            // The RF returns the old value when read and write share this edge.
            fwd1_v <= req_use1 & wb_hit(wb_ok, wb_addr, req_sr1);
            fwd2_v <= req_use2 & wb_hit(wb_ok, wb_addr, req_sr2);
            fwd1_d <= wb_data;
            fwd2_d <= wb_data;
          end
        end
        CAPT: begin
          op_a     <= cap_a;
          op_b     <= cap_b;
          op_valid <= 1'b1;
        end
        HOLD: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            fwd1_v   <= 1'b0;
            fwd2_v   <= 1'b0;
          end else begin
            if (use1_q && wb_hit(wb_ok, wb_addr, sr1_q)) op_a <= wb_data;
            if (use2_q && wb_hit(wb_ok, wb_addr, sr2_q)) op_b <= wb_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Directed bench for reg_access_seq with a behavioural 16-entry registered-read
// register file attached to the rf_* pins.
module tb_reg_access_seq;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_CAPT = 32'd1;
  localparam logic [31:0] S_HOLD = 32'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_sr1, req_sr2;
  logic          req_use1, req_use2;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          err;
  logic [1:0]    rf_readreg;
  logic [AW-1:0] rf_sr1, rf_sr2, rf_dr;
  logic          rf_wreg, rf_muxa2;
  logic [DW-1:0] rf_wrData, rf_rdData1, rf_rdData2;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rf_mem [16];

  reg_access_seq #(.NREG(16), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sr1(req_sr1), .req_sr2(req_sr2),
    .req_use1(req_use1), .req_use2(req_use2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err),
    .rf_readreg(rf_readreg), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_dr(rf_dr),
    .rf_wreg(rf_wreg), .rf_muxa2(rf_muxa2), .rf_wrData(rf_wrData),
    .rf_rdData1(rf_rdData1), .rf_rdData2(rf_rdData2),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Register file model: registered read returns the pre-write value on a shared edge.
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    rf_rdData1 = '0;
    rf_rdData2 = '0;
  end

  always @(posedge clk) begin
    if (rf_readreg[1]) rf_rdData1 <= rf_mem[rf_sr1[3:0]];
    if (rf_readreg[0]) rf_rdData2 <= rf_mem[rf_sr2[3:0]];
    if (rf_wreg) rf_mem[rf_dr[3:0]] <= rf_wrData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic u1, input logic u2);
    req_valid = v;
    req_sr1   = s1;
    req_sr2   = s2;
    req_use1  = u1;
    req_use2  = u2;
  endtask

  task automatic drive_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    op_ready = 1'b0;
    drive_req(1'b1, 5'd3, 5'd4, 1'b1, 1'b1);
    drive_wb(1'b1, 5'd3, 32'hDEAD);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wb_ready", 32'(wb_ready), 0);
    check("rst_readreg", 32'(rf_readreg), 0);
    check("rst_wreg", 32'(rf_wreg), 0);
    cyc();
    cyc();
    rst = 1'b0;
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    drive_wb(1'b0, '0, '0);
    #1;
    check("post_rst_op_valid", 32'(op_valid), 0);
    check("post_rst_op_a", op_a, 0);
    check("post_rst_op_b", op_b, 0);
    check("post_rst_err", 32'(err), 0);
    check("post_rst_muxa2", 32'(rf_muxa2), 0);
    check("post_rst_req_ready", 32'(req_ready), 1);
    check("post_rst_state", 32'(fsm_state), S_IDLE);

    // Write then read
    drive_wb(1'b1, 5'd3, 32'h12);
    #1;
    check("wb_wreg", 32'(rf_wreg), 1);
    check("wb_dr", 32'(rf_dr), 3);
    check("wb_data", rf_wrData, 32'h12);
    cyc();
    drive_wb(1'b1, 5'd15, 32'h2);
    cyc();
    drive_wb(1'b0, '0, '0);
    drive_req(1'b1, 5'd3, 5'd15, 1'b1, 1'b1);
    #1;
    check("rd_readreg", 32'(rf_readreg), 32'b11);
    check("rd_sr2", 32'(rf_sr2), 15);
    cyc();
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    check("rd_capt_state", 32'(fsm_state), S_CAPT);
    check("rd_capt_op_valid", 32'(op_valid), 0);
    check("rd_capt_req_ready", 32'(req_ready), 0);
    cyc();
    check("rd_hold_op_valid", 32'(op_valid), 1);
    check("rd_op_a", op_a, 32'h12);
    check("rd_op_b", op_b, 32'h2);
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    check("rd_done_op_valid", 32'(op_valid), 0);
    check("rd_done_state", 32'(fsm_state), S_IDLE);

    // Same-cycle write forwarding
    drive_wb(1'b1, 5'd5, 32'h01);
    cyc();
    drive_wb(1'b1, 5'd5, 32'hAA);
    drive_req(1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    check("fw_readreg", 32'(rf_readreg), 32'b10);
    cyc();
    drive_wb(1'b0, '0, '0);
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    check("fw_op_a", op_a, 32'hAA);
    check("fw_op_b_unused", op_b, 0);

    // HOLD update under backpressure (held cycle 1 is the current one)
    cyc();
    drive_wb(1'b1, 5'd5, 32'hBB);
    cyc();
    drive_wb(1'b0, '0, '0);
    check("hold_op_a_upd", op_a, 32'hBB);
    check("hold_op_valid", 32'(op_valid), 1);
    cyc();
    check("hold_op_valid_4", 32'(op_valid), 1);
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    check("hold_clr_op_valid", 32'(op_valid), 0);
    check("hold_clr_op_a", op_a, 0);

    // Out-of-range read, single operand
    drive_req(1'b1, 5'd20, 5'd0, 1'b1, 1'b0);
    #1;
    check("oor_readreg", 32'(rf_readreg), 32'b10);
    cyc();
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    check("oor_err_capt", 32'(err), 1);
    cyc();
    check("oor_err_clear", 32'(err), 0);
    check("oor_op_a", op_a, 0);
    check("oor_op_b", op_b, 0);
    check("oor_op_valid", 32'(op_valid), 1);
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;

    // Out-of-range write
    drive_wb(1'b1, 5'd17, 32'h55);
    #1;
    check("oorw_wreg", 32'(rf_wreg), 0);
    check("oorw_wb_ready", 32'(wb_ready), 1);
    check("oorw_err_before", 32'(err), 0);
    cyc();
    drive_wb(1'b0, '0, '0);
    check("oorw_err", 32'(err), 1);
    cyc();
    check("oorw_err_clear", 32'(err), 0);
    check("oorw_r1_intact", rf_mem[1], 0);

    // Reset during CAPT
    drive_req(1'b1, 5'd3, 5'd5, 1'b1, 1'b1);
    cyc();
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    check("mid_capt_state", 32'(fsm_state), S_CAPT);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_op_valid", 32'(op_valid), 0);
    check("mid_state", 32'(fsm_state), S_IDLE);
    cyc();
    check("mid_op_valid_2", 32'(op_valid), 0);
    drive_req(1'b1, 5'd5, 5'd3, 1'b1, 1'b1);
    cyc();
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    check("mid_next_state", 32'(fsm_state), S_HOLD);
    check("mid_next_op_a", op_a, 32'hBB);
    check("mid_next_op_b", op_b, 32'h12);
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    check("mid_next_done", 32'(op_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
